// File: rtl/bomb_game_ctrl.sv
// -----------------------------------------------------------------------------
// bomb_game_ctrl
//
// Purpose: single registered FSM that runs one bomb-defusal session: arming,
// 60 s BCD countdown, capture of four 2-bit code symbols on enter presses,
// code check, attempt counting and the defused/exploded verdict.
//
// Optional feature macro: BOMB_PENALTY_EN
//   defined   -> each wrong code that leaves tries remaining costs 10 s
//   undefined -> a wrong code only consumes an attempt
//
// Parameters:
//   CODE        defusal code, symbol k in bits [2k+1:2k]
//   START_TENS  countdown tens digit loaded on arm
//   START_UNITS countdown units digit loaded on arm
//   MAX_TRIES   wrong codes allowed before explosion (1-3)
//
// Ports:
//   clk        in   system clock, rising edge
//   clr        in   synchronous active-low reset
//   start      in   one-cycle arm request
//   enter_n    in   raw enter pushbutton, active-low, asynchronous
//   sym        in   code symbol from switches
//   tick       in   one-cycle 1 Hz pulse
//   tens       out  countdown tens digit (BCD)
//   units      out  countdown units digit (BCD)
//   entry      out  symbols captured so far, packed like CODE
//   entry_cnt  out  number of symbols captured (0-4)
//   tries_left out  remaining attempts
//   armed      out  session running (ARMED or CHECK)
//   defused    out  code accepted
//   exploded   out  timer expired or attempts exhausted
//   blink      out  toggles on each tick while defused
// -----------------------------------------------------------------------------
module bomb_game_ctrl #(
    parameter logic [7:0] CODE        = 8'b10_11_01_00,
    parameter int         START_TENS  = 5,
    parameter int         START_UNITS = 9,
    parameter int         MAX_TRIES   = 3
) (
    input  logic       clk,
    input  logic       clr,
    input  logic       start,
    input  logic       enter_n,
    input  logic [1:0] sym,
    input  logic       tick,
    output logic [3:0] tens,
    output logic [3:0] units,
    output logic [7:0] entry,
    output logic [2:0] entry_cnt,
    output logic [1:0] tries_left,
    output logic       armed,
    output logic       defused,
    output logic       exploded,
    output logic       blink
);

    localparam logic [3:0] LD_TENS  = 4'(START_TENS);
    localparam logic [3:0] LD_UNITS = 4'(START_UNITS);
    localparam logic [1:0] LD_TRIES = 2'(MAX_TRIES);

    typedef enum logic [2:0] {
        S_IDLE,
        S_ARMED,
        S_CHECK,
        S_DEFUSED,
        S_EXPLODED
    } state_t;

    state_t     r_state;
    logic [3:0] r_tens;
    logic [3:0] r_units;
    logic [7:0] r_entry;
    logic [2:0] r_entry_cnt;
    logic [1:0] r_tries;
    logic       r_armed;
    logic       r_defused;
    logic       r_exploded;
    logic       r_blink;
    logic       r_sync1;
    logic       r_sync2;
    logic       r_sync2_d;

    state_t     w_state_nx;
    logic [3:0] w_tens_nx;
    logic [3:0] w_units_nx;
    logic [7:0] w_entry_nx;
    logic [2:0] w_entry_cnt_nx;
    logic [1:0] w_tries_nx;
    logic       w_blink_nx;
    logic [7:0] w_dec;
    logic       w_press;
    logic       w_zero;

    // One-second BCD decrement. Callers never pass 00.
    function automatic logic [7:0] bcd_dec(input logic [3:0] t, input logic [3:0] u);
        if (u == 4'd0)
            return {t - 4'd1, 4'd9};
        else
            return {t, u - 4'd1};
    endfunction

    // Falling edge of the synchronized button. The sync flops reset to 1, so a
    // button held through reset produces at most a press while still IDLE.
    assign w_press = r_sync2_d & ~r_sync2;
    assign w_zero  = (r_tens == 4'd0) && (r_units == 4'd0);
    assign w_dec   = bcd_dec(r_tens, r_units);

    always_comb begin
        w_state_nx     = r_state;
        w_tens_nx      = r_tens;
        w_units_nx     = r_units;
        w_entry_nx     = r_entry;
        w_entry_cnt_nx = r_entry_cnt;
        w_tries_nx     = r_tries;
        w_blink_nx     = r_blink;

        case (r_state)
            S_IDLE, S_DEFUSED, S_EXPLODED: begin
                if (start) begin
                    w_state_nx     = S_ARMED;
                    w_tens_nx      = LD_TENS;
                    w_units_nx     = LD_UNITS;
                    w_entry_nx     = 8'd0;
                    w_entry_cnt_nx = 3'd0;
                    w_tries_nx     = LD_TRIES;
                    w_blink_nx     = 1'b0;
                end else if ((r_state == S_DEFUSED) && tick) begin
                    w_blink_nx = ~r_blink;
                end
            end

            S_ARMED, S_CHECK: begin
                // An expired timer overrides any pending press or code check.
                if (w_zero) begin
                    w_state_nx = S_EXPLODED;
                end else begin
                    if (tick) begin
                        {w_tens_nx, w_units_nx} = w_dec;
                    end
                    if (r_state == S_ARMED) begin
                        if (w_press) begin
                            w_entry_nx[{r_entry_cnt[1:0], 1'b0} +: 2] = sym;
                            w_entry_cnt_nx = r_entry_cnt + 3'd1;
                            if (r_entry_cnt == 3'd3)
                                w_state_nx = S_CHECK;
                        end
                    end else begin
                        if (r_entry == CODE) begin
                            w_state_nx = S_DEFUSED;
                        end else begin
                            w_tries_nx = r_tries - 2'd1;
                            if (r_tries == 2'd1) begin
                                w_state_nx = S_EXPLODED;
                            end else begin
`ifdef BOMB_PENALTY_EN
                                // Penalty applies after this cycle's tick; with
                                // no tens left the timer hits 00 and expires.
                                if (w_tens_nx == 4'd0)
                                    w_units_nx = 4'd0;
                                else
                                    w_tens_nx = w_tens_nx - 4'd1;
`endif
                                w_entry_nx     = 8'd0;
                                w_entry_cnt_nx = 3'd0;
                                w_state_nx     = S_ARMED;
                            end
                        end
                    end
                end
            end

            default: w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            r_state     <= S_IDLE;
            r_tens      <= 4'd0;
            r_units     <= 4'd0;
            r_entry     <= 8'd0;
            r_entry_cnt <= 3'd0;
            r_tries     <= 2'd0;
            r_armed     <= 1'b0;
            r_defused   <= 1'b0;
            r_exploded  <= 1'b0;
            r_blink     <= 1'b0;
            r_sync1     <= 1'b1;
            r_sync2     <= 1'b1;
            r_sync2_d   <= 1'b1;
        end else begin
            r_state     <= w_state_nx;
            r_tens      <= w_tens_nx;
            r_units     <= w_units_nx;
            r_entry     <= w_entry_nx;
            r_entry_cnt <= w_entry_cnt_nx;
            r_tries     <= w_tries_nx;
            r_armed     <= (w_state_nx == S_ARMED) || (w_state_nx == S_CHECK);
            r_defused   <= (w_state_nx == S_DEFUSED);
            r_exploded  <= (w_state_nx == S_EXPLODED);
            r_blink     <= w_blink_nx;
            r_sync1     <= enter_n;
            r_sync2     <= r_sync1;
            r_sync2_d   <= r_sync2;
        end
    end

    assign tens       = r_tens;
    assign units      = r_units;
    assign entry      = r_entry;
    assign entry_cnt  = r_entry_cnt;
    assign tries_left = r_tries;
    assign armed      = r_armed;
    assign defused    = r_defused;
    assign exploded   = r_exploded;
    assign blink      = r_blink;

endmodule

// File: tb/tb_bomb_game_ctrl.sv
// -----------------------------------------------------------------------------
// tb_bomb_game_ctrl
//
// Scoreboard bench for bomb_game_ctrl. The driver applies one set of inputs per
// clock and pushes the reference model's expected outputs; a monitor pops and
// compares after every rising edge. The model tracks the countdown as whole
// seconds, the entry as a symbol list and the session as a phase, and models
// the button synchronizer as a delay line of sampled levels.
// -----------------------------------------------------------------------------
module tb_bomb_game_ctrl;

    localparam logic [7:0] TB_CODE = 8'b10_11_01_00;
    localparam int TB_SECS  = 59;
    localparam int TB_TRIES = 3;

    localparam int P_IDLE = 0;
    localparam int P_ARM  = 1;
    localparam int P_CHK  = 2;
    localparam int P_DEF  = 3;
    localparam int P_EXP  = 4;

    logic       clk = 1'b0;
    logic       clr = 1'b0;
    logic       start = 1'b0;
    logic       enter_n = 1'b1;
    logic [1:0] sym = 2'd0;
    logic       tick = 1'b0;
    logic [3:0] tens;
    logic [3:0] units;
    logic [7:0] entry;
    logic [2:0] entry_cnt;
    logic [1:0] tries_left;
    logic       armed;
    logic       defused;
    logic       exploded;
    logic       blink;

    bomb_game_ctrl dut (
        .clk       (clk),
        .clr       (clr),
        .start     (start),
        .enter_n   (enter_n),
        .sym       (sym),
        .tick      (tick),
        .tens      (tens),
        .units     (units),
        .entry     (entry),
        .entry_cnt (entry_cnt),
        .tries_left(tries_left),
        .armed     (armed),
        .defused   (defused),
        .exploded  (exploded),
        .blink     (blink)
    );

    always #5 clk = ~clk;

    logic [24:0] exp_q[$];
    int  total = 0;
    int  bad = 0;
    int  cyc_no = 0;
    bit  mon_en = 0;

    // Reference model state.
    int         m_phase = P_IDLE;
    int         m_secs = 0;
    int         m_tries = 0;
    int         m_cnt = 0;
    logic [7:0] m_entry = 8'd0;
    bit         m_blink = 0;
    bit         h0 = 1, h1 = 1, h2 = 1;   // button levels sampled 1, 2, 3 edges ago

    task automatic model_step(input bit c, input bit s, input bit e,
                              input logic [1:0] sy, input bit t);
        bit pr;
        if (!c) begin
            m_phase = P_IDLE; m_secs = 0; m_tries = 0; m_cnt = 0;
            m_entry = 8'd0; m_blink = 0; h0 = 1; h1 = 1; h2 = 1;
            return;
        end
        pr = h2 && !h1;
        h2 = h1; h1 = h0; h0 = e;
        if (m_phase == P_IDLE || m_phase == P_DEF || m_phase == P_EXP) begin
            if (s) begin
                m_phase = P_ARM; m_secs = TB_SECS; m_tries = TB_TRIES;
                m_cnt = 0; m_entry = 8'd0; m_blink = 0;
            end else if (m_phase == P_DEF && t) begin
                m_blink = !m_blink;
            end
        end else if (m_secs == 0) begin
            m_phase = P_EXP;
        end else begin
            if (t) m_secs = m_secs - 1;
            if (m_phase == P_ARM) begin
                if (pr) begin
                    m_entry = m_entry | (8'(sy) << (2 * m_cnt));
                    m_cnt = m_cnt + 1;
                    if (m_cnt == 4) m_phase = P_CHK;
                end
            end else if (m_entry == TB_CODE) begin
                m_phase = P_DEF;
            end else begin
                m_tries = m_tries - 1;
                if (m_tries == 0) begin
                    m_phase = P_EXP;
                end else begin
`ifdef BOMB_PENALTY_EN
                    m_secs = (m_secs < 10) ? 0 : m_secs - 10;
`endif
                    m_entry = 8'd0; m_cnt = 0; m_phase = P_ARM;
                end
            end
        end
    endtask

    function automatic logic [24:0] model_out();
        logic [3:0] t, u;
        t = 4'(m_secs / 10);
        u = 4'(m_secs % 10);
        return {t, u, m_entry, 3'(m_cnt), 2'(m_tries),
                (m_phase == P_ARM || m_phase == P_CHK), (m_phase == P_DEF),
                (m_phase == P_EXP), m_blink};
    endfunction

    task automatic cyc(input bit c, input bit s, input bit e,
                       input logic [1:0] sy, input bit t);
        @(negedge clk);
        clr = c; start = s; enter_n = e; sym = sy; tick = t;
        model_step(c, s, e, sy, t);
        exp_q.push_back(model_out());
        mon_en = 1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, 2'd0, 0);
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) cyc(1, 0, 1, 2'd0, 1);
    endtask

    // Presses start 5 cycles apart; capture lands on the third cycle.
    task automatic press_sym(input logic [1:0] s);
        cyc(1, 0, 0, s, 0);
        cyc(1, 0, 0, s, 0);
        cyc(1, 0, 1, s, 0);
        cyc(1, 0, 1, s, 0);
        cyc(1, 0, 1, s, 0);
    endtask

    task automatic code_correct();
        logic [7:0] c;
        c = TB_CODE;
        for (int k = 0; k < 4; k++) press_sym(c[2*k +: 2]);
    endtask

    task automatic code_wrong();
        for (int k = 0; k < 4; k++) press_sym(2'd0);
    endtask

    // Monitor: compare the registered outputs after every rising edge.
    initial begin
        logic [24:0] got, want;
        forever begin
            @(posedge clk);
            #1;
            cyc_no++;
            got = {tens, units, entry, entry_cnt, tries_left, armed, defused, exploded, blink};
            if (exp_q.size() > 0) begin
                want = exp_q.pop_front();
                total++;
                if (got !== want) begin
                    bad++;
                    $display("FAIL outputs cyc=%0d got t=%0d u=%0d e=%b n=%0d tr=%0d a/d/x/b=%b want t=%0d u=%0d e=%b n=%0d tr=%0d a/d/x/b=%b",
                             cyc_no, got[24:21], got[20:17], got[16:9], got[8:6], got[5:4], got[3:0],
                             want[24:21], want[20:17], want[16:9], want[8:6], want[5:4], want[3:0]);
                end
            end else if (mon_en) begin
                total++;
                bad++;
                $display("FAIL scoreboard cyc=%0d got no expected entry, required one per cycle", cyc_no);
            end
        end
    end

    initial begin
        int en_hold;
        bit en_lvl;
        logic [7:0] c;
        logic [1:0] s;
        c = TB_CODE;

        // Reset and free-running countdown to explosion, then extra ticks.
        cyc(0, 0, 1, 2'd0, 0);
        cyc(0, 0, 1, 2'd0, 0);
        idle(3);
        cyc(1, 1, 1, 2'd0, 0);
        ticks(63);
        idle(2);

        // Correct code, then blink while defused.
        cyc(1, 1, 1, 2'd0, 0);
        code_correct();
        idle(3);
        for (int i = 0; i < 4; i++) begin
            ticks(1);
            idle(2);
        end

        // Three wrong codes, then re-arm.
        cyc(1, 1, 1, 2'd0, 0);
        code_wrong();
        idle(3);
        code_wrong();
        idle(2);
        code_wrong();
        idle(3);
        cyc(1, 1, 1, 2'd0, 0);
        idle(3);

        // Timer reaches 00 on the edge that captures the 4th correct symbol.
        ticks(58);
        for (int k = 0; k < 3; k++) press_sym(c[2*k +: 2]);
        s = c[7:6];
        cyc(1, 0, 0, s, 0);
        cyc(1, 0, 0, s, 0);
        cyc(1, 0, 1, s, 1);
        idle(4);

        // Reset mid-entry with the button held low across reset release.
        cyc(1, 1, 1, 2'd0, 0);
        press_sym(c[1:0]);
        press_sym(c[3:2]);
        cyc(0, 0, 0, 2'd0, 0);
        for (int i = 0; i < 6; i++) cyc(1, 0, 0, 2'd0, 0);
        cyc(1, 1, 0, 2'd0, 0);
        for (int i = 0; i < 4; i++) cyc(1, 0, 0, 2'd0, 0);
        idle(4);

        // Randomized session traffic.
        en_hold = 0;
        en_lvl = 1;
        for (int i = 0; i < 5000; i++) begin
            bit rc, rs, rt;
            if (en_hold == 0) begin
                en_lvl = !en_lvl;
                en_hold = $urandom_range(1, 6);
            end
            en_hold--;
            if (m_cnt < 4 && ($urandom % 10) < 7)
                s = c[2*m_cnt +: 2];
            else
                s = 2'($urandom);
            rc = (($urandom % 800) != 0);
            rs = (($urandom % 150) == 0) ||
                 ((m_phase == P_DEF || m_phase == P_EXP || m_phase == P_IDLE) && ($urandom % 25) == 0);
            rt = (($urandom % 6) == 0);
            cyc(rc, rs, en_lvl, s, rt);
        end

        @(posedge clk);
        #2;
        mon_en = 0;
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL drain leftover=%0d required=0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
